// File: rtl/sram_4096b_reader.sv
// sram_4096b_reader: streams a block of wide SRAM words as MSB-first beats.
// Ports: clk, rst (sync, active-high); iStart/iBase_addr/iNum_words request;
//   oR_en/oR_addr/iSram_data SRAM read port (data one cycle after oR_en);
//   oBeat/oBeat_valid/iBeat_ready beat handshake; oBusy, oDone status.
// Optional macro READER_PREFETCH_EN adds a shadow buffer for zero-bubble
//   word-to-word streaming.
module sram_4096b_reader #(
  parameter int DATA_W = 4096,
  parameter int BEAT_W = 128,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iBase_addr,
  input  logic [ADDR_W:0]   iNum_words,
  output logic              oR_en,
  output logic [ADDR_W-1:0] oR_addr,
  input  logic [DATA_W-1:0] iSram_data,
  output logic [BEAT_W-1:0] oBeat,
  output logic              oBeat_valid,
  input  logic              iBeat_ready,
  output logic              oBusy,
  output logic              oDone
);

  localparam int NBEATS = DATA_W / BEAT_W;
  localparam int IDX_W  = $clog2(NBEATS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBEATS - 1);
  localparam logic [ADDR_W:0]  ONE  = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, STREAM, DONE
  } state_e;

  state_e            state_q;
  logic              r_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] buf_q;
  logic [BEAT_W-1:0] beat_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
`ifdef READER_PREFETCH_EN
  logic [DATA_W-1:0] sh_q;
  logic              sh_full_q;
  logic              pend_q;
`endif

  logic accept;
  assign accept = valid_q && iBeat_ready;

  // Beat k is the k-th BEAT_W slice counted from the MSB end.
  function automatic logic [BEAT_W-1:0] slice(
    input logic [DATA_W-1:0] w,
    input logic [IDX_W-1:0]  k
  );
    logic [DATA_W-1:0] s;
    s = w << (32'(k) * BEAT_W);
    return s[DATA_W-1 -: BEAT_W];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      r_en_q    <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      buf_q     <= '0;
      beat_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef READER_PREFETCH_EN
      sh_q      <= '0;
      sh_full_q <= 1'b0;
      pend_q    <= 1'b0;
`endif
    end else begin
      r_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iStart) begin
            busy_q <= 1'b1;
            addr_q <= iBase_addr;
            rem_q  <= iNum_words;
            if (iNum_words == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= READ;
              r_en_q  <= 1'b1;
            end
          end
        end
        READ: state_q <= WAIT;
        WAIT: begin
          buf_q   <= iSram_data;
          beat_q  <= slice(iSram_data, '0);
          idx_q   <= '0;
          valid_q <= 1'b1;
          state_q <= STREAM;
        end
        STREAM: begin
`ifdef READER_PREFETCH_EN
          // Fetch the next word into the shadow while streaming.
          pend_q <= r_en_q;
          if (pend_q) begin
            sh_q      <= iSram_data;
            sh_full_q <= 1'b1;
          end
          if (rem_q > ONE && !sh_full_q
              && !pend_q && !r_en_q) begin
            r_en_q <= 1'b1;
            addr_q <= addr_q + 1'b1;
          end
`endif
          if (accept) begin
            if (idx_q != LAST) begin
              idx_q  <= idx_q + 1'b1;
              beat_q <= slice(buf_q, idx_q + 1'b1);
            end else if (rem_q > ONE) begin
              rem_q <= rem_q - ONE;
`ifdef READER_PREFETCH_EN
              buf_q     <= sh_q;
              beat_q    <= slice(sh_q, '0);
              idx_q     <= '0;
              sh_full_q <= 1'b0;
`else
              valid_q <= 1'b0;
              state_q <= READ;
              r_en_q  <= 1'b1;
              addr_q  <= addr_q + 1'b1;
`endif
            end else begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          // An empty block arrives here with done_q low:
          // spend one busy cycle, then pulse done.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oR_en       = r_en_q;
  assign oR_addr     = addr_q;
  assign oBeat       = beat_q;
  assign oBeat_valid = valid_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;

endmodule

// File: tb/tb_sram_4096b_reader.sv
// tb_sram_4096b_reader: scoreboard bench for sram_4096b_reader.
// SRAM model + reference block model feed queues; a monitor checks.
module tb_sram_4096b_reader;

  localparam int DW = 4096;
  localparam int BW = 128;
  localparam int NB = DW / BW;
`ifdef READER_PREFETCH_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    base = '0;
  logic [8:0]    num = '0;
  logic          r_en;
  logic [7:0]    r_addr;
  logic [DW-1:0] sram_data = '0;
  logic [BW-1:0] beat;
  logic          beat_valid;
  logic          ready = 1'b1;
  logic          busy;
  logic          done;

  sram_4096b_reader dut (
    .clk(clk), .rst(rst),
    .iStart(start), .iBase_addr(base), .iNum_words(num),
    .oR_en(r_en), .oR_addr(r_addr), .iSram_data(sram_data),
    .oBeat(beat), .oBeat_valid(beat_valid),
    .iBeat_ready(ready), .oBusy(busy), .oDone(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [BW-1:0] mem_b [256][NB];

  function automatic logic [DW-1:0] word_of(input logic [7:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < NB; k++) w[DW-1-k*BW -: BW] = mem_b[a][k];
    return w;
  endfunction

  function automatic logic [DW-1:0] junk();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  always @(posedge clk) begin
    if (r_en) sram_data <= word_of(r_addr);
    else sram_data <= junk();
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_v(input string nm,
                       input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  logic [BW-1:0] beat_q [$];
  logic [7:0]    addr_q [$];

  int acked, done_cnt, ren_cnt;
  int t_ren, t_first, t_last, t_done, t_ack31, t_gap;
  bit held;
  logic [BW-1:0] held_beat;

  task automatic clear_stats();
    acked = 0; done_cnt = 0; ren_cnt = 0;
    t_ren = -1; t_first = -1; t_last = -1; t_done = -1;
    t_ack31 = -1; t_gap = -1; held = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  initial begin
    clear_stats();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (r_en) begin
          ren_cnt++;
          if (t_ren < 0) t_ren = cyc;
          if (!busy) fail("ren_not_busy");
          if (addr_q.size() == 0) fail("extra_read");
          else chk_i("raddr", int'(r_addr), int'(addr_q.pop_front()));
        end
        if (done) begin
          done_cnt++;
          t_done = cyc;
          chk_i("busy_at_done", int'(busy), 0);
        end
        if (beat_valid) begin
          if (held) chk_v("hold", beat, held_beat);
          if (acked == NB && t_gap < 0 && t_ack31 >= 0)
            t_gap = cyc - t_ack31;
          if (ready) begin
            if (beat_q.size() == 0) fail("extra_beat");
            else chk_v("beat", beat, beat_q.pop_front());
            if (acked == 0) t_first = cyc;
            if (acked == NB-1) t_ack31 = cyc;
            t_last = cyc;
            acked++;
            held = 0;
          end else begin
            held = 1;
            held_beat = beat;
          end
        end else begin
          if (held) fail("valid_dropped");
          held = 0;
        end
      end
    end
  end

  int rmode = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: ready = ~ready;
        2: ready = ($urandom_range(0, 3) != 0);
        default: ready = 1'b1;
      endcase
    end
  end

  int t_start;

  task automatic start_blk(input logic [7:0] b, input logic [8:0] n);
    logic [7:0] a;
    @(posedge clk); #1;
    clear_stats();
    beat_q.delete();
    addr_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      a = 8'(int'(b) + i);
      addr_q.push_back(a);
      for (int k = 0; k < NB; k++) beat_q.push_back(mem_b[a][k]);
    end
    base = b; num = n; start = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base = 8'($urandom);
    num = 9'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) fail("timeout_done");
  endtask

  task automatic end_blk();
    repeat (3) @(negedge clk);
    chk_i("done_count", done_cnt, 1);
    chk_i("beats_left", beat_q.size(), 0);
    chk_i("reads_left", addr_q.size(), 0);
  endtask

  task automatic run_blk(input logic [7:0] b, input logic [8:0] n);
    start_blk(b, n);
    wait_done(int'(n) * NB * 8 + 100);
    end_blk();
  endtask

  initial begin
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < NB; k++)
        mem_b[a][k] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < NB; k++) mem_b[8'h10][k] = BW'(k);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_i("rst_ren", int'(r_en), 0);
    chk_i("rst_addr", int'(r_addr), 0);
    chk_v("rst_beat", beat, '0);
    chk_i("rst_valid", int'(beat_valid), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_done", int'(done), 0);

    // Single word latency
    run_blk(8'h10, 9'd1);
    chk_i("lat_ren", t_ren - t_start, 1);
    chk_i("lat_first", t_first - t_start, 3);
    chk_i("lat_last", t_last - t_start, 34);
    chk_i("lat_done", t_done - t_start, 35);

    // Address wrap
    run_blk(8'hFF, 9'd2);
    chk_i("wrap_beats", acked, 2*NB);
    chk_i("wrap_gap", t_gap, GAP);

    // Ready toggling
    rmode = 1;
    run_blk(8'($urandom), 9'd2);
    chk_i("tog_beats", acked, 2*NB);
    chk_i("tog_gap", t_gap, GAP);
    rmode = 0;

    // Empty block
    run_blk(8'h33, 9'd0);
    chk_i("zero_done_lat", t_done - t_start, 2);
    chk_i("zero_reads", ren_cnt, 0);
    chk_i("zero_beats", acked, 0);

    // Reset mid-block
    start_blk(8'($urandom), 9'd4);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acked >= 10) break;
    end
    chk_i("rst_reach10", int'(acked >= 10), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_i("mrst_ren", int'(r_en), 0);
    chk_i("mrst_addr", int'(r_addr), 0);
    chk_v("mrst_beat", beat, '0);
    chk_i("mrst_valid", int'(beat_valid), 0);
    chk_i("mrst_busy", int'(busy), 0);
    chk_i("mrst_done", int'(done), 0);
    beat_q.delete();
    addr_q.delete();
    clear_stats();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk_i("mrst_no_done", done_cnt, 0);
    chk_i("mrst_no_read", ren_cnt, 0);
    run_blk(8'($urandom), 9'd2);

    // iStart while busy and during the done cycle
    start_blk(8'h80, 9'd3);
    repeat (20) @(posedge clk);
    #1;
    base = 8'h05; num = 9'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk_i("busy_mid", int'(busy), 1);
    wait_done(3*NB*8 + 100);
    base = 8'h44; num = 9'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_i("ign_done_cnt", done_cnt, 1);
    chk_i("ign_beats", beat_q.size(), 0);
    ren_cnt = 0;
    repeat (6) @(negedge clk);
    chk_i("ign_no_read", ren_cnt, 0);
    chk_i("ign_not_busy", int'(busy), 0);

    // Random blocks with random backpressure
    rmode = 2;
    for (int r = 0; r < 6; r++)
      run_blk(8'($urandom), 9'($urandom_range(1, 4)));
    rmode = 0;

    // Full 256-word block
    run_blk(8'($urandom), 9'd256);
    chk_i("full_beats", acked, 256*NB);
    chk_i("full_reads", ren_cnt, 256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_4096b_reader.md
SRAM_4096B_READER -- requirements
Module: sram_4096b_reader

Interface
REQ-001 Parameter DATA_W, default 4096, width of one SRAM word.
REQ-002 Parameter BEAT_W, default 128, width of one output beat; DATA_W/BEAT_W = 32 beats per word.
REQ-003 Parameter ADDR_W, default 8, SRAM address width (256 words).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 iStart  in  1  one-cycle request to stream a block; ignored while oBusy=1.
REQ-007 iBase_addr  in  ADDR_W  first SRAM word address, sampled with iStart.
REQ-008 iNum_words  in  ADDR_W+1  words to stream (0..256), sampled with iStart.
REQ-009 oR_en  out  1  SRAM read enable.
REQ-010 oR_addr  out  ADDR_W  SRAM read address.
REQ-011 iSram_data  in  DATA_W  SRAM read data, valid the cycle after oR_en=1.
REQ-012 oBeat  out  BEAT_W  current output beat.
REQ-013 oBeat_valid  out  1  oBeat holds valid data.
REQ-014 iBeat_ready  in  1  downstream accepts oBeat when high with oBeat_valid.
REQ-015 oBusy  out  1  high from cycle after accepted iStart until oDone.
REQ-016 oDone  out  1  one-cycle pulse at block completion.

Function
REQ-017 States IDLE, READ, WAIT, STREAM, DONE; encoded in one state register.
REQ-018 IDLE + iStart: latch address/count; count=0 -> DONE next cycle; else -> READ.
REQ-019 READ: oR_en=1, oR_addr=current address for exactly one cycle -> WAIT.
REQ-020 WAIT: register iSram_data into word buffer -> STREAM.
REQ-021 iStart at cycle 0 -> oR_en at cycle 1, first oBeat_valid at cycle 3.
REQ-022 Beat k (0..31) = buffer bits [DATA_W-1-k*BEAT_W -: BEAT_W]; beat 0 is the MSB slice.
REQ-023 Beat index advances only on oBeat_valid && iBeat_ready; oBeat and oBeat_valid stay stable while not accepted.
REQ-024 Acceptance of beat 31: words remaining -> READ with address+1; else -> DONE.
REQ-025 Address increments modulo 2^ADDR_W (255 wraps to 0).
REQ-026 DONE: oDone=1 for one cycle, oBusy=0 in that cycle -> IDLE; iStart in the DONE cycle is ignored.
REQ-027 oR_en is never high in IDLE, STREAM (unless REQ-032 applies) or DONE.
REQ-028 iNum_words=256 streams 256 words, 8192 beats.

Reset
REQ-029 rst=1: state IDLE; oR_en, oR_addr, oBeat, oBeat_valid, oBusy, oDone, counters and buffers all zero.
REQ-030 rst mid-block aborts transfer next edge; no oDone, no further oR_en; iStart accepted the first cycle after rst deasserts.
REQ-031 rst has priority over iStart and handshake in the same cycle.

Configuration
REQ-032 Macro READER_PREFETCH_EN defined: second DATA_W shadow buffer; in STREAM, when words remain and shadow empty, issue next read (oR_en one cycle) and capture data the following cycle; at beat-31 acceptance, shadow moves to word buffer and beat 0 of next word is valid the next cycle (zero bubble).
REQ-033 READER_PREFETCH_EN undefined: no shadow buffer; next word beat 0 is valid 3 cycles after beat-31 acceptance (READ, WAIT, STREAM).
REQ-034 Beat order, data values, oDone timing relative to last beat, and reset behaviour identical in both builds.

Verification
REQ-035 iStart, base 0x10, count 1, ready=1, SRAM word = beat k holds value k -> oR_en cycle 1 addr 0x10, beats 0..31 on cycles 3..34, oDone cycle 35.
REQ-036 Base 0xFF, count 2 -> oR_addr 0xFF then 0x00; 64 beats in order; one oDone.
REQ-037 Count 2, ready toggled 1/0 each cycle -> oBeat held when ready=0; no beat lost or duplicated; beat gap at word boundary 3 cycles (1 with READER_PREFETCH_EN).
REQ-038 Count 0 -> no oR_en, no oBeat_valid, oDone 2 cycles after iStart.
REQ-039 rst asserted at beat 10 of word 0 of a 4-word block -> all outputs 0 next cycle, no oDone; new iStart afterwards streams correctly.
REQ-040 iStart pulsed while oBusy=1 -> ignored; address/count of the active block unchanged.
